buzzer_tone_gen: RTL and testbench
==================================

// Module: buzzer_tone_gen
// PURPOSE
//  Turns a 4-bit note code from the song player (auto/free/learn modes) into a
//  50%-duty square wave for the on-board passive buzzer. Sits directly after the
//  player and drives the buzzer pin; holds no song state, only the current tone.
// PARAMETERS
//  CLK_HZ      100_000_000  system clock frequency; sets every half-period count
//  GAP_CYCLES  2_000_000    silent cycles between differing notes (20 ms @100 MHz)
//  CNT_W       18           half-period counter width; must hold CLK_HZ/(2*262)
// PORTS
//  clk       in   1   system clock, rising edge
//  rst_n     in   1   asynchronous active-low reset
//  en        in   1   1 = sound allowed; 0 = force silence
//  note_in   in   4   note code: 0 = rest, 1..7 = C4..B4, 8..14 = C5..B5, 15 = C6
//  buzz      out  1   square wave to buzzer pin
//  sounding  out  1   1 while state is TONE (buzz toggling)
//  note_cur  out  4   note code currently adopted (registered)
// BEHAVIOUR
//  Frequencies (Hz) 1..15: 262 294 330 349 392 440 494 523 587 659 698 784 880 988 1047.
//  HALF(n) = CLK_HZ/(2*f(n)), integer truncation, constant table (combinational on note_cur).
//  HALF at default CLK_HZ: A4 (code 6) = 113636; C4 = 190839; C6 = 47755.
//  Reset: buzz=0, sounding=0, note_cur=0, cnt=0, state=REST. All outputs registered.
//  States: REST (buzz=0), GAP (buzz=0, counting gap), TONE (toggling).
//  Every edge: note_in sampled; "change" = note_in != note_cur.
//  On change: note_cur<=note_in, cnt<=0, buzz<=0 in that same edge.
//   - new code 0 -> REST.
//   - new code !=0 -> TONE (GAP if BUZZER_ARTIC_EN, see below).
//  TONE: cnt increments each cycle; at cnt==HALF-1, cnt<=0 and buzz toggles.
//   First rising edge of buzz occurs HALF cycles after the change edge.
//   Identical consecutive codes are not a change: wave continues without phase reset.
//  en=0: state<=REST, buzz<=0, cnt<=0 next edge; note_cur still tracks note_in.
//  en 0->1 with note_cur!=0: enter TONE (or GAP) with cnt=0, buzz=0, as for a change.
//  Change outranks counter terminal count on the same edge.
//  sounding = (state==TONE). No other output depends on note_in combinationally.
//  Async reset mid-tone: buzz drops to 0 immediately, no glitch after release.
// CONFIGURATION
//  Macro BUZZER_ARTIC_EN:
//   defined: a change to a non-zero code enters GAP; gap counter counts
//    GAP_CYCLES cycles with buzz=0, sounding=0, then TONE with cnt=0.
//    Change during GAP restarts the gap with the new code; change to 0 -> REST.
//    Total delay change->first buzz rise = GAP_CYCLES + HALF.
//   undefined: GAP state and gap counter not synthesised; change goes straight
//    to TONE; GAP_CYCLES ignored.
// TESTING
//  1 Reset: rst_n=0 while note_in=6 -> buzz=0, sounding=0, note_cur=0 throughout.
//  2 note_in=6, en=1 (no ARTIC) -> buzz rises 113636 cycles after change, period
//    227272 cycles, duty exactly 50%, sounding=1.
//  3 6 -> 6 held across 5 periods -> no phase reset; 6 -> 15 mid-high-phase ->
//    buzz=0 next edge, first rise 47755 cycles later.
//  4 note_in=0 while toning -> REST next edge, buzz=0, sounding=0; en=0 likewise
//    silences; en back to 1 restarts tone from cnt=0.
//  5 BUZZER_ARTIC_EN, GAP_CYCLES=100, 1 -> 8 -> buzz low 100 cycles then rise
//    after 100+95602; change to 3 at gap cycle 50 -> gap restarts from 0.
//  6 rst_n pulsed low mid-TONE with buzz=1 -> buzz=0 asynchronously, REST on release.

Source files
------------

// File: rtl/buzzer_tone_gen_if.sv
// Player-to-buzzer tone interface: enable and note code in, wave and status out.
interface buzzer_tone_gen_if;
   logic       en;
   logic [3:0] note_in;
   logic       buzz;
   logic       sounding;
   logic [3:0] note_cur;

   modport master (
      output en,
      output note_in,
      input  buzz,
      input  sounding,
      input  note_cur
   );

   modport slave (
      input  en,
      input  note_in,
      output buzz,
      output sounding,
      output note_cur
   );
endinterface

// File: rtl/buzzer_tone_gen.sv
// Note code to 50%-duty buzzer square wave. Define BUZZER_ARTIC_EN to insert a
// silent gap of GAP_CYCLES between differing notes.
module buzzer_tone_gen #(
   parameter int unsigned CLK_HZ     = 100_000_000,
   parameter int unsigned GAP_CYCLES = 2_000_000,
   parameter int unsigned CNT_W      = 18
) (
   input  logic              clk,
   input  logic              rst_n,
   buzzer_tone_gen_if.slave  bus
);

`ifdef BUZZER_ARTIC_EN
   typedef enum logic [1:0] {StRest, StGap, StTone} state_e;
   localparam int unsigned GapW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
`else
   typedef enum logic [1:0] {StRest, StTone} state_e;
`endif

   state_e           r_state;
   state_e           w_state_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic             r_buzz;
   logic             w_buzz_nxt;
   logic [3:0]       r_note_cur;
   logic [CNT_W-1:0] w_half;
   logic             w_change;
   logic             w_restart;
   logic             w_term;

`ifdef BUZZER_ARTIC_EN
   logic [GapW-1:0]  r_gap;
   logic [GapW-1:0]  w_gap_nxt;
`else
   logic             w_unused_gap;
   assign w_unused_gap = ^GAP_CYCLES;
`endif

   // Half-period table, constant per note, decoded from the adopted code
   always_comb begin
      w_half = '0;
      case (r_note_cur)
         4'd1:    w_half = CNT_W'(CLK_HZ / (2 * 262));
         4'd2:    w_half = CNT_W'(CLK_HZ / (2 * 294));
         4'd3:    w_half = CNT_W'(CLK_HZ / (2 * 330));
         4'd4:    w_half = CNT_W'(CLK_HZ / (2 * 349));
         4'd5:    w_half = CNT_W'(CLK_HZ / (2 * 392));
         4'd6:    w_half = CNT_W'(CLK_HZ / (2 * 440));
         4'd7:    w_half = CNT_W'(CLK_HZ / (2 * 494));
         4'd8:    w_half = CNT_W'(CLK_HZ / (2 * 523));
         4'd9:    w_half = CNT_W'(CLK_HZ / (2 * 587));
         4'd10:   w_half = CNT_W'(CLK_HZ / (2 * 659));
         4'd11:   w_half = CNT_W'(CLK_HZ / (2 * 698));
         4'd12:   w_half = CNT_W'(CLK_HZ / (2 * 784));
         4'd13:   w_half = CNT_W'(CLK_HZ / (2 * 880));
         4'd14:   w_half = CNT_W'(CLK_HZ / (2 * 988));
         4'd15:   w_half = CNT_W'(CLK_HZ / (2 * 1047));
         default: w_half = '0;
      endcase
   end

   assign w_change = (bus.note_in != r_note_cur);
   // REST with a live note can only follow en=0, so this also catches en 0->1
   assign w_restart = w_change || ((r_state == StRest) && (r_note_cur != 4'd0));
   assign w_term = (r_cnt == (w_half - CNT_W'(1)));

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_buzz_nxt  = r_buzz;
`ifdef BUZZER_ARTIC_EN
      w_gap_nxt   = r_gap;
`endif
      if (!bus.en) begin
         w_state_nxt = StRest;
         w_cnt_nxt   = '0;
         w_buzz_nxt  = 1'b0;
      end else if (w_restart) begin
         w_cnt_nxt  = '0;
         w_buzz_nxt = 1'b0;
         if (bus.note_in == 4'd0) begin
            w_state_nxt = StRest;
         end else begin
`ifdef BUZZER_ARTIC_EN
            w_state_nxt = StGap;
            w_gap_nxt   = '0;
`else
            w_state_nxt = StTone;
`endif
         end
      end else begin
         case (r_state)
            StTone: begin
               if (w_term) begin
                  w_cnt_nxt  = '0;
                  w_buzz_nxt = ~r_buzz;
               end else begin
                  w_cnt_nxt = r_cnt + CNT_W'(1);
               end
            end
`ifdef BUZZER_ARTIC_EN
            StGap: begin
               if (r_gap == GapW'(GAP_CYCLES - 1)) begin
                  w_state_nxt = StTone;
                  w_cnt_nxt   = '0;
               end else begin
                  w_gap_nxt = r_gap + GapW'(1);
               end
            end
`endif
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= StRest;
         r_cnt      <= '0;
         r_buzz     <= 1'b0;
         r_note_cur <= 4'd0;
      end else begin
         r_state    <= w_state_nxt;
         r_cnt      <= w_cnt_nxt;
         r_buzz     <= w_buzz_nxt;
         r_note_cur <= bus.note_in;
      end
   end

`ifdef BUZZER_ARTIC_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_gap <= '0;
      end else begin
         r_gap <= w_gap_nxt;
      end
   end
`endif

   assign bus.buzz     = r_buzz;
   assign bus.sounding = (r_state == StTone);
   assign bus.note_cur = r_note_cur;

endmodule

// File: tb/tb_buzzer_tone_gen.sv
// Directed bench for buzzer_tone_gen at a scaled-down clock so tones are short.
module tb_buzzer_tone_gen;
   localparam int H1  = 381;  // 200000 / 524
   localparam int H3  = 303;  // 200000 / 660
   localparam int H6  = 227;  // 200000 / 880
   localparam int H8  = 191;  // 200000 / 1046
   localparam int H15 = 95;   // 200000 / 2094
`ifdef BUZZER_ARTIC_EN
   localparam int GAP = 100;
`else
   localparam int GAP = 0;
`endif
   localparam int SND_CHG = (GAP == 0) ? 1 : 0;

   logic clk;
   logic rst_n;
   int   total;
   int   bad;
   int   n;

   buzzer_tone_gen_if bus ();

   buzzer_tone_gen #(
      .CLK_HZ     (200_000),
      .GAP_CYCLES (100),
      .CNT_W      (18)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic edges(input int k);
      repeat (k) @(posedge clk);
      #1;
   endtask

   task automatic count_to(input logic lvl, output int cnt);
      cnt = 0;
      while (bus.buzz !== lvl && cnt < 5000) begin
         @(posedge clk);
         #1;
         cnt++;
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst_n = 1'b0;
      bus.en = 1'b1;
      bus.note_in = 4'd6;

      edges(3);
      chk("rst_buzz", bus.buzz, 0);
      chk("rst_sounding", bus.sounding, 0);
      chk("rst_note_cur", bus.note_cur, 0);

      @(negedge clk);
      rst_n = 1'b1;
      edges(1);
      chk("chg_note_cur", bus.note_cur, 6);
      chk("chg_sounding", bus.sounding, SND_CHG);
      chk("chg_buzz", bus.buzz, 0);
      count_to(1'b1, n);
      chk("a4_first_rise", n, GAP + H6);
      chk("a4_sounding", bus.sounding, 1);
      for (int p = 0; p < 5; p++) begin
         count_to(1'b0, n);
         chk("a4_hold_high", n, H6);
         count_to(1'b1, n);
         chk("a4_hold_low", n, H6);
      end

      // 6 -> 15 partway through a high phase
      edges(100);
      chk("mid_high", bus.buzz, 1);
      bus.note_in = 4'd15;
      edges(1);
      chk("c6_chg_buzz", bus.buzz, 0);
      chk("c6_note_cur", bus.note_cur, 15);
      count_to(1'b1, n);
      chk("c6_first_rise", n, GAP + H15);

      bus.note_in = 4'd0;
      edges(1);
      chk("rest_sounding", bus.sounding, 0);
      chk("rest_buzz", bus.buzz, 0);
      chk("rest_note_cur", bus.note_cur, 0);
      edges(20);
      chk("rest_hold_buzz", bus.buzz, 0);

      bus.note_in = 4'd1;
      edges(51);
      bus.en = 1'b0;
      edges(1);
      chk("en0_sounding", bus.sounding, 0);
      chk("en0_buzz", bus.buzz, 0);
      bus.note_in = 4'd8;
      edges(1);
      chk("en0_track", bus.note_cur, 8);
      chk("en0_still_silent", bus.sounding, 0);
      edges(30);
      chk("en0_hold_buzz", bus.buzz, 0);
      bus.en = 1'b1;
      edges(1);
      chk("en1_buzz", bus.buzz, 0);
      chk("en1_sounding", bus.sounding, SND_CHG);
      count_to(1'b1, n);
      chk("en1_first_rise", n, GAP + H8);

      // change lands on the same edge as the low-phase terminal count
      count_to(1'b0, n);
      chk("c5_high", n, H8);
      edges(H8 - 1);
      chk("pre_tc_buzz", bus.buzz, 0);
      bus.note_in = 4'd6;
      edges(1);
      chk("chg_over_tc", bus.buzz, 0);
      count_to(1'b1, n);
      chk("chg_over_tc_rise", n, GAP + H6);

      edges(10);
      chk("pre_arst_buzz", bus.buzz, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_buzz", bus.buzz, 0);
      chk("arst_sounding", bus.sounding, 0);
      chk("arst_note_cur", bus.note_cur, 0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("release_rest", bus.sounding, 0);
      edges(1);
      chk("release_buzz", bus.buzz, 0);
      chk("release_note_cur", bus.note_cur, 6);
      count_to(1'b1, n);
      chk("release_rise", n, GAP + H6);

`ifdef BUZZER_ARTIC_EN
      bus.note_in = 4'd1;
      edges(1);
      count_to(1'b1, n);
      chk("gap_c4_rise", n, GAP + H1);
      bus.note_in = 4'd8;
      edges(1);
      chk("gap_sounding", bus.sounding, 0);
      chk("gap_buzz", bus.buzz, 0);
      count_to(1'b1, n);
      chk("gap_c5_rise", n, GAP + H8);
      bus.note_in = 4'd1;
      edges(50);
      chk("gap_mid_sounding", bus.sounding, 0);
      bus.note_in = 4'd3;
      edges(1);
      count_to(1'b1, n);
      chk("gap_restart_rise", n, GAP + H3);
`else
      bus.note_in = 4'd1;
      edges(1);
      count_to(1'b1, n);
      chk("c4_first_rise", n, H1);
      bus.note_in = 4'd3;
      edges(1);
      count_to(1'b1, n);
      chk("e4_first_rise", n, H3);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
